// File: rtl/mu_pkg.sv
// Shared definitions for the multiply-unit sequencer and the EX controller.
package mu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned OP_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DONE  = 2'b10,
    ST_DRAIN = 2'b11
  } mu_state_e;

  typedef enum logic [OP_W-1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mu_op_e;

endpackage

// File: rtl/mu_watchdog.sv
// Cycle counter bounding how long the sequencer waits on the MU.
module mu_watchdog #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the last permitted wait cycle so the FSM leaves on the next edge.
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mu_sequencer.sv
// Issues mul-class requests to the multicycle MU, stalls EX until the result
// is back, and holds it until EX advances; handles flush and MU timeout.
module mu_sequencer
  import mu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [OP_W-1:0]       req_op,
  input  logic [XLEN-1:0]       req_a,
  input  logic [XLEN-1:0]       req_b,
  input  logic [REG_ADDR_W-1:0] req_rd,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  mu_start,
  output logic [OP_W-1:0]       mu_op,
  output logic [XLEN-1:0]       mu_a,
  output logic [XLEN-1:0]       mu_b,
  input  logic                  mu_done,
  input  logic [XLEN-1:0]       mu_result,
  output logic                  stall,
  output logic                  res_valid,
  output logic [XLEN-1:0]       res_data,
  output logic [REG_ADDR_W-1:0] res_rd,
  output logic                  res_err,
  output logic                  busy
);

  mu_state_e             state_q, state_d;
  logic                  mu_start_q, mu_start_d;
  logic [OP_W-1:0]       mu_op_q, mu_op_d;
  logic [XLEN-1:0]       mu_a_q, mu_a_d;
  logic [XLEN-1:0]       mu_b_q, mu_b_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       res_data_q, res_data_d;
  logic                  res_err_q, res_err_d;
  logic                  res_valid_q;
  logic                  busy_q;
  logic                  accept_c;
  logic                  expired;

  mu_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept_c),
    .en      ((state_q == ST_BUSY) || (state_q == ST_DRAIN)),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    mu_start_d = 1'b0;
    mu_op_d    = mu_op_q;
    mu_a_d     = mu_a_q;
    mu_b_d     = mu_b_q;
    rd_d       = rd_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          accept_c   = 1'b1;
          mu_start_d = 1'b1;
          mu_op_d    = req_op;
          mu_a_d     = req_a;
          mu_b_d     = req_b;
          rd_d       = req_rd;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mu_done) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            res_data_d = mu_result;
            res_err_d  = 1'b0;
            state_d    = ST_DONE;
          end
        end else if (expired) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            res_data_d = '0;
            res_err_d  = 1'b1;
            state_d    = ST_DONE;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (flush || ex_ready) begin
          state_d = ST_IDLE;
        end
      end
      // MU cannot abort: swallow its eventual result (or give up on timeout).
      ST_DRAIN: begin
        if (mu_done || expired) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mu_start_q  <= 1'b0;
      mu_op_q     <= '0;
      mu_a_q      <= '0;
      mu_b_q      <= '0;
      rd_q        <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mu_start_q  <= mu_start_d;
      mu_op_q     <= mu_op_d;
      mu_a_q      <= mu_a_d;
      mu_b_q      <= mu_b_d;
      rd_q        <= rd_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // Drops in the DONE cycle with ex_ready so EX advances exactly once.
  assign stall = ((state_q == ST_IDLE) && req_valid && !flush) ||
                 (state_q == ST_BUSY) ||
                 ((state_q == ST_DONE) && !ex_ready && !flush) ||
                 ((state_q == ST_DRAIN) && req_valid);

  assign mu_start  = mu_start_q;
  assign mu_op     = mu_op_q;
  assign mu_a      = mu_a_q;
  assign mu_b      = mu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_rd    = rd_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mu_sequencer.sv
// Directed bench for mu_sequencer; the MU is played by the stimulus sequence.
module tb_mu_sequencer;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned TIMEOUT = 8;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            err;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic [4:0]      req_rd;
  logic            flush;
  logic            ex_ready;
  logic            mu_start;
  logic [1:0]      mu_op;
  logic [XLEN-1:0] mu_a;
  logic [XLEN-1:0] mu_b;
  logic            mu_done;
  logic [XLEN-1:0] mu_result;
  logic            stall;
  logic            res_valid;
  logic [XLEN-1:0] res_data;
  logic [4:0]      res_rd;
  logic            res_err;
  logic            busy;

  int   n_chk      = 0;
  int   n_fail     = 0;
  int   n_starts   = 0;
  int   exp_starts = 0;
  exp_t sb[$];
  exp_t cur;
  logic rv_prev    = 1'b0;

  mu_sequencer #(
    .XLEN    (XLEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rd    (req_rd),
    .flush     (flush),
    .ex_ready  (ex_ready),
    .mu_start  (mu_start),
    .mu_op     (mu_op),
    .mu_a      (mu_a),
    .mu_b      (mu_b),
    .mu_done   (mu_done),
    .mu_result (mu_result),
    .stall     (stall),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_rd    (res_rd),
    .res_err   (res_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [4:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
  endtask

  function automatic exp_t mk(input logic [4:0] rd, input logic [XLEN-1:0] data, input logic err);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    e.err  = err;
    return e;
  endfunction

  // Scoreboard: pop on each new result, then hold it stable while res_valid stays up.
  always @(negedge clk) begin
    if (rst) begin
      rv_prev = 1'b0;
    end else begin
      if (mu_start) n_starts++;
      if (res_valid) begin
        if (!rv_prev) begin
          n_chk++;
          assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected: observed result %0h expected none", res_data);
          end
          if (sb.size() != 0) cur = sb.pop_front();
        end
        chk("sb_data", res_data, cur.data);
        chk("sb_rd", XLEN'(res_rd), XLEN'(cur.rd));
        chk1("sb_err", res_err, cur.err);
      end
      rv_prev = res_valid;
    end
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_rd = '0;
    flush = 1'b0; ex_ready = 1'b0; mu_done = 1'b0; mu_result = '0;
    tick(); tick();
    chk1("rst_mu_start", mu_start, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    rst = 1'b0;

    // Basic issue, MU latency 3
    ex_ready = 1'b1;
    drive_req(2'b00, 7, 6, 5); #1;
    chk1("t1_stall_accept", stall, 1'b1);
    sb.push_back(mk(5, 42, 1'b0)); exp_starts++;
    tick(); req_valid = 1'b0; #1;
    chk1("t1_mu_start", mu_start, 1'b1);
    chk("t1_mu_a", mu_a, 7);
    chk("t1_mu_b", mu_b, 6);
    chk("t1_mu_op", XLEN'(mu_op), 0);
    chk1("t1_busy", busy, 1'b1);
    chk1("t1_stall_busy", stall, 1'b1);
    tick();
    chk1("t1_start_once", mu_start, 1'b0);
    tick(); tick();
    mu_done = 1'b1; mu_result = 42; #1;
    chk1("t1_stall_done_cyc", stall, 1'b1);
    tick(); mu_done = 1'b0; #1;
    chk1("t1_res_valid", res_valid, 1'b1);
    chk("t1_res_data", res_data, 42);
    chk("t1_res_rd", XLEN'(res_rd), 5);
    chk1("t1_stall_release", stall, 1'b0);
    tick();
    chk1("t1_valid_drop", res_valid, 1'b0);
    chk1("t1_idle", busy, 1'b0);

    // Downstream backpressure
    ex_ready = 1'b0;
    drive_req(2'b00, 7, 6, 9);
    sb.push_back(mk(9, 42, 1'b0)); exp_starts++;
    tick(); req_valid = 1'b0;
    tick(); tick(); tick();
    mu_done = 1'b1; mu_result = 42;
    tick(); mu_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("t2_held_valid", res_valid, 1'b1);
      chk("t2_held_data", res_data, 42);
      chk1("t2_held_stall", stall, 1'b1);
      chk1("t2_no_restart", mu_start, 1'b0);
      tick();
    end
    ex_ready = 1'b1; #1;
    chk1("t2_last_valid", res_valid, 1'b1);
    chk1("t2_stall_release", stall, 1'b0);
    tick();
    chk1("t2_valid_drop", res_valid, 1'b0);
    chk1("t2_idle", busy, 1'b0);

    // Flush in BUSY, request waits in DRAIN
    drive_req(2'b00, 9, 11, 6); exp_starts++;
    tick(); req_valid = 1'b0;
    tick(); flush = 1'b1; #1;
    chk1("t3_stall_flush", stall, 1'b1);
    tick(); flush = 1'b0;
    chk1("t3_drain_busy", busy, 1'b1);
    drive_req(2'b00, 3, 4, 7); #1;
    chk1("t3_drain_stall", stall, 1'b1);
    tick(); mu_done = 1'b1; mu_result = 99; #1;
    chk1("t3_drain_stall2", stall, 1'b1);
    tick(); mu_done = 1'b0; #1;
    chk1("t3_back_idle", busy, 1'b0);
    chk1("t3_stall_accept", stall, 1'b1);
    chk1("t3_no_early_start", mu_start, 1'b0);
    sb.push_back(mk(7, 12, 1'b0)); exp_starts++;
    tick(); req_valid = 1'b0;
    chk1("t3_mu_start", mu_start, 1'b1);
    chk("t3_mu_a", mu_a, 3);
    chk("t3_mu_b", mu_b, 4);
    tick(); mu_done = 1'b1; mu_result = 12;
    tick(); mu_done = 1'b0;
    chk1("t3_res_valid", res_valid, 1'b1);
    chk("t3_res_data", res_data, 12);
    tick();
    chk1("t3_valid_drop", res_valid, 1'b0);

    // Flush and mu_done together in BUSY
    drive_req(2'b10, 5, 5, 8); exp_starts++;
    tick(); req_valid = 1'b0;
    tick(); flush = 1'b1; mu_done = 1'b1; mu_result = 55;
    tick(); flush = 1'b0; mu_done = 1'b0;
    chk1("t4a_idle", busy, 1'b0);
    chk1("t4a_no_valid", res_valid, 1'b0);

    // Flush while the result is held in DONE
    ex_ready = 1'b0;
    drive_req(2'b11, 6, 6, 10);
    sb.push_back(mk(10, 66, 1'b0)); exp_starts++;
    tick(); req_valid = 1'b0;
    tick(); mu_done = 1'b1; mu_result = 66;
    tick(); mu_done = 1'b0;
    chk1("t4b_done_valid", res_valid, 1'b1);
    flush = 1'b1; #1;
    chk1("t4b_flush_stall", stall, 1'b0);
    tick(); flush = 1'b0;
    chk1("t4b_dropped", res_valid, 1'b0);
    chk1("t4b_idle", busy, 1'b0);

    // Watchdog: MU never answers
    drive_req(2'b00, 1, 1, 12);
    sb.push_back(mk(12, 0, 1'b1)); exp_starts++;
    tick(); req_valid = 1'b0;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      chk1("t5_waiting_busy", busy, 1'b1);
      chk1("t5_waiting_valid", res_valid, 1'b0);
      tick();
    end
    chk1("t5_timeout_valid", res_valid, 1'b1);
    chk1("t5_timeout_err", res_err, 1'b1);
    chk("t5_timeout_data", res_data, 0);
    tick(); mu_done = 1'b1; mu_result = 77;
    tick(); mu_done = 1'b0;
    chk1("t5_late_valid", res_valid, 1'b1);
    chk("t5_late_data", res_data, 0);
    chk1("t5_late_err", res_err, 1'b1);
    ex_ready = 1'b1;
    tick();
    chk1("t5_idle", busy, 1'b0);

    // Reset mid-operation, then in-flight / spurious mu_done
    drive_req(2'b01, 32'h1234, 32'h55, 11); exp_starts++;
    tick(); req_valid = 1'b0;
    chk("t6_mu_a_latched", mu_a, 32'h1234);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    chk1("t6_mu_start", mu_start, 1'b0);
    chk("t6_mu_op", XLEN'(mu_op), 0);
    chk("t6_mu_a", mu_a, 0);
    chk("t6_mu_b", mu_b, 0);
    chk("t6_res_rd", XLEN'(res_rd), 0);
    chk1("t6_res_err", res_err, 1'b0);
    chk1("t6_busy", busy, 1'b0);
    mu_done = 1'b1; mu_result = 88;
    tick(); mu_done = 1'b0;
    chk1("t6_spurious_valid", res_valid, 1'b0);
    chk("t6_spurious_data", res_data, 0);
    chk1("t6_spurious_busy", busy, 1'b0);

    // Recovery at minimum MU latency
    drive_req(2'b00, 2, 5, 4);
    sb.push_back(mk(4, 10, 1'b0)); exp_starts++;
    tick(); req_valid = 1'b0;
    tick(); mu_done = 1'b1; mu_result = 10;
    tick(); mu_done = 1'b0;
    chk1("t7_res_valid", res_valid, 1'b1);
    tick();
    chk1("t7_idle", busy, 1'b0);

    tick();
    chk("sb_drained", XLEN'(sb.size()), 0);
    chk("start_count", XLEN'(n_starts), XLEN'(exp_starts));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
